// File: rtl/flash_loader.sv
// Boot-time copy engine: reads LENGTH bytes from the flash controller starting
// at BASE_ADDR and writes them, byte by byte, into a block RAM write port.
module flash_loader #(
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int unsigned LENGTH     = 4096,
    parameter int unsigned ADDR_W     = 12,
    parameter logic        AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [23:0]       flash_addr,
    output logic              request_read_addr,
    output logic              request_read_next,
    input  logic              d_ready,
    input  logic [7:0]        d_in,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REQ_ADDR  = 3'd1;
    localparam logic [2:0] S_WAIT_LOW  = 3'd2;
    localparam logic [2:0] S_WAIT_HIGH = 3'd3;
    localparam logic [2:0] S_WRITE     = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LENGTH - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              auto_pending_q, auto_pending_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [23:0]       flash_addr_q, flash_addr_d;
    logic              req_addr_q, req_addr_d;
    logic              req_next_q, req_next_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        auto_pending_d = auto_pending_q;
        busy_d         = busy_q;
        done_d         = done_q;
        flash_addr_d   = BASE_ADDR;
        req_addr_d     = 1'b0;
        req_next_d     = 1'b0;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Request pulse is launched with acceptance so it lines up with busy.
                if (start || auto_pending_q) begin
                    auto_pending_d = 1'b0;
                    done_d         = 1'b0;
                    busy_d         = 1'b1;
                    idx_d          = '0;
                    req_addr_d     = 1'b1;
                    state_d        = S_REQ_ADDR;
                end
            end
            S_REQ_ADDR: begin
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                // d_ready may still show the previous byte right after a request.
                if (!d_ready) begin
                    state_d = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (d_ready) begin
                    mem_data_d = d_in;
                    mem_addr_d = idx_q;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    req_next_d = 1'b1;
                    idx_d      = idx_q + ADDR_W'(1);
                    state_d    = S_WAIT_LOW;
                end
            end
            S_FINISH: begin
                // Runs during the final write strobe, so done follows it by one cycle.
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            auto_pending_q <= AUTO_START;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            flash_addr_q   <= BASE_ADDR;
            req_addr_q     <= 1'b0;
            req_next_q     <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            auto_pending_q <= auto_pending_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            flash_addr_q   <= flash_addr_d;
            req_addr_q     <= req_addr_d;
            req_next_q     <= req_next_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign flash_addr        = flash_addr_q;
    assign request_read_addr = req_addr_q;
    assign request_read_next = req_next_q;
    assign mem_we            = mem_we_q;
    assign mem_addr          = mem_addr_q;
    assign mem_data          = mem_data_q;

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: two instances (LENGTH=4 auto-start, LENGTH=1 manual)
// driven by a flash-controller model with stale d_ready after each request.
module tb_flash_loader;

    logic        clk;
    logic        rst      [2];
    logic        start_i  [2];
    logic        busy     [2];
    logic        done     [2];
    logic [23:0] fa       [2];
    logic        rra      [2];
    logic        rrn      [2];
    logic        dr       [2];
    logic [7:0]  din      [2];
    logic        we       [2];
    logic [11:0] maddr    [2];
    logic [7:0]  mdata    [2];

    int n_cmp;
    int n_bad;
    int cyc;

    // Model state, per instance
    bit          copying   [2];
    bit          done_m    [2];
    bit          auto_pend [2];
    int          acc_cyc   [2];
    int          r_cyc     [2];
    int          phase     [2];
    int          wr_cnt    [2];
    int          rra_cnt   [2];
    int          rrn_cnt   [2];
    bit          we_prev   [2];
    logic [11:0] maddr_prev[2];
    logic [7:0]  mdata_prev[2];
    bit          fm_act    [2];
    int          fm_t      [2];
    logic [23:0] fm_ptr    [2];
    logic [11:0] log_a     [2][4];
    logic [7:0]  log_d     [2][4];

    logic [7:0]  img0 [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};

    flash_loader #(
        .BASE_ADDR (24'h000000),
        .LENGTH    (4),
        .ADDR_W    (12),
        .AUTO_START(1'b1)
    ) u_dut0 (
        .clk(clk), .reset(rst[0]), .start(start_i[0]), .busy(busy[0]), .done(done[0]),
        .flash_addr(fa[0]), .request_read_addr(rra[0]), .request_read_next(rrn[0]),
        .d_ready(dr[0]), .d_in(din[0]), .mem_we(we[0]), .mem_addr(maddr[0]), .mem_data(mdata[0])
    );

    flash_loader #(
        .BASE_ADDR (24'h000105),
        .LENGTH    (1),
        .ADDR_W    (12),
        .AUTO_START(1'b0)
    ) u_dut1 (
        .clk(clk), .reset(rst[1]), .start(start_i[1]), .busy(busy[1]), .done(done[1]),
        .flash_addr(fa[1]), .request_read_addr(rra[1]), .request_read_next(rrn[1]),
        .d_ready(dr[1]), .d_in(din[1]), .mem_we(we[1]), .mem_addr(maddr[1]), .mem_data(mdata[1])
    );

    function automatic int len_of(input int id);
        return (id == 0) ? 4 : 1;
    endfunction

    function automatic logic [23:0] base_of(input int id);
        return (id == 0) ? 24'h000000 : 24'h000105;
    endfunction

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        return 8'hA0 + a[7:0];
    endfunction

    task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] @cyc %0d: got %0h expected %0h", nm, id, cyc, act, exp);
        end
    endtask

    // One cycle of the reference model, evaluated mid-cycle.
    task automatic step(input int id);
        int          len;
        logic [23:0] base;
        bit          exp_we;
        bit          idle;
        len  = len_of(id);
        base = base_of(id);
        if (rst[id]) begin
            cmp("rst_busy",  id, busy[id],  0);
            cmp("rst_done",  id, done[id],  0);
            cmp("rst_rra",   id, rra[id],   0);
            cmp("rst_rrn",   id, rrn[id],   0);
            cmp("rst_we",    id, we[id],    0);
            cmp("rst_maddr", id, maddr[id], 0);
            cmp("rst_mdata", id, mdata[id], 0);
            cmp("rst_faddr", id, fa[id],    base);
            copying[id]   = 0;
            done_m[id]    = 0;
            auto_pend[id] = (id == 0);
            acc_cyc[id]   = -100;
            r_cyc[id]     = -100;
            phase[id]     = 0;
            wr_cnt[id]    = 0;
            we_prev[id]   = 0;
            fm_act[id]    = 0;
            dr[id]        = 0;
            din[id]       = 8'h00;
            return;
        end

        exp_we = (phase[id] == 3) && (r_cyc[id] + 2 == cyc);
        cmp("busy",  id, busy[id], copying[id]);
        cmp("done",  id, done[id], done_m[id]);
        cmp("rra",   id, rra[id],  (acc_cyc[id] + 1 == cyc));
        cmp("faddr", id, fa[id],   base);
        cmp("we",    id, we[id],   exp_we);
        cmp("rrn",   id, rrn[id],  exp_we && (wr_cnt[id] < len - 1));
        if (phase[id] == 3 && (r_cyc[id] + 1 == cyc || exp_we)) begin
            cmp("maddr", id, maddr[id], wr_cnt[id]);
            cmp("mdata", id, mdata[id], fbyte(base + 24'(wr_cnt[id])));
        end
        if (we_prev[id]) begin
            cmp("maddr_hold", id, maddr[id], maddr_prev[id]);
            cmp("mdata_hold", id, mdata[id], mdata_prev[id]);
        end
        if (rra[id]) rra_cnt[id]++;
        if (rrn[id]) rrn_cnt[id]++;
        we_prev[id]    = we[id];
        maddr_prev[id] = maddr[id];
        mdata_prev[id] = mdata[id];

        idle = !copying[id];
        if (we[id]) begin
            if (wr_cnt[id] < 4) begin
                log_a[id][wr_cnt[id]] = maddr[id];
                log_d[id][wr_cnt[id]] = mdata[id];
            end
            wr_cnt[id]++;
            phase[id] = 0;
            if (wr_cnt[id] == len) begin
                copying[id] = 0;
                done_m[id]  = 1;
            end
        end
        if (idle && (start_i[id] || auto_pend[id])) begin
            acc_cyc[id]   = cyc;
            auto_pend[id] = 0;
            done_m[id]    = 0;
            copying[id]   = 1;
            wr_cnt[id]    = 0;
        end

        // Flash controller: previous byte stays visible for 2 cycles after a request.
        if (rra[id]) begin
            fm_ptr[id] = fa[id];
            fm_t[id]   = 0;
            fm_act[id] = 1;
        end else if (rrn[id]) begin
            fm_ptr[id] = fm_ptr[id] + 24'd1;
            fm_t[id]   = 0;
            fm_act[id] = 1;
        end else if (fm_act[id]) begin
            fm_t[id]++;
            if (fm_t[id] == 2) begin
                dr[id]  = 0;
                din[id] = 8'h5A;
            end
            if (fm_t[id] == 2 + (fm_ptr[id][0] ? 4 : 3)) begin
                dr[id]     = 1;
                din[id]    = fbyte(fm_ptr[id]);
                fm_act[id] = 0;
            end
        end

        if (rra[id] || rrn[id]) begin
            phase[id] = 1;
        end else if (phase[id] == 1 && !dr[id]) begin
            phase[id] = 2;
        end else if (phase[id] == 2 && dr[id]) begin
            phase[id] = 3;
            r_cyc[id] = cyc;
        end
    endtask

    task automatic clear_stats(input int id);
        rra_cnt[id] = 0;
        rrn_cnt[id] = 0;
        for (int i = 0; i < 4; i++) begin
            log_a[id][i] = 12'hFFF;
            log_d[id][i] = 8'h00;
        end
    endtask

    task automatic wait_done(input int id, input int budget);
        int n;
        n = 0;
        while (done[id] !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        cmp("done_timeout", id, done[id], 1);
    endtask

    task automatic check_image0(input string nm);
        cmp({nm, "_done"},  0, done[0],    1);
        cmp({nm, "_busy"},  0, busy[0],    0);
        cmp({nm, "_rra_n"}, 0, rra_cnt[0], 1);
        cmp({nm, "_rrn_n"}, 0, rrn_cnt[0], 3);
        cmp({nm, "_wr_n"},  0, wr_cnt[0],  4);
        for (int i = 0; i < 4; i++) begin
            cmp({nm, "_addr"}, 0, log_a[0][i], i);
            cmp({nm, "_data"}, 0, log_d[0][i], img0[i]);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int id = 0; id < 2; id++) step(id);
        end
    end

    initial begin
        int n;
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst[0] = 1; rst[1] = 1;
        start_i[0] = 0; start_i[1] = 0;
        dr[0] = 0; dr[1] = 0;
        din[0] = 8'h00; din[1] = 8'h00;
        clear_stats(0);
        clear_stats(1);

        // Auto-start copy of 4 bytes after reset release
        repeat (3) @(posedge clk);
        #1 rst[0] = 0;
        wait_done(0, 300);
        cmp("A_faddr", 0, fa[0], 24'h000000);
        check_image0("A");

        // LENGTH=1, manual start only
        @(posedge clk); #1 rst[1] = 0;
        repeat (4) @(posedge clk);
        #1;
        cmp("B_no_auto_busy", 1, busy[1], 0);
        cmp("B_no_auto_done", 1, done[1], 0);
        start_i[1] = 1;
        @(posedge clk); #1 start_i[1] = 0;
        cmp("B_busy_t1", 1, busy[1], 1);
        cmp("B_rra_t1",  1, rra[1],  1);
        wait_done(1, 100);
        cmp("B_busy",  1, busy[1],     0);
        cmp("B_wr_n",  1, wr_cnt[1],   1);
        cmp("B_rrn_n", 1, rrn_cnt[1],  0);
        cmp("B_rra_n", 1, rra_cnt[1],  1);
        cmp("B_addr",  1, log_a[1][0], 12'h000);
        cmp("B_data",  1, log_d[1][0], 8'hA5);

        // Restart after done, with start pulses during the copy
        clear_stats(0);
        start_i[0] = 1;
        @(posedge clk); #1 start_i[0] = 0;
        cmp("C_done_drop", 0, done[0], 0);
        cmp("C_busy_t1",   0, busy[0], 1);
        for (int k = 0; k < 5; k++) begin
            repeat (2) @(posedge clk);
            #1 start_i[0] = 1;
            @(posedge clk); #1 start_i[0] = 0;
            cmp("C_busy_hold", 0, busy[0], 1);
        end
        wait_done(0, 300);
        check_image0("C");

        // Reset in the middle of a copy, after index 2 is written
        clear_stats(0);
        start_i[0] = 1;
        @(posedge clk); #1 start_i[0] = 0;
        n = 0;
        while (wr_cnt[0] < 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        cmp("D_reach_idx2", 0, wr_cnt[0], 3);
        rst[0] = 1;
        @(posedge clk); #1;
        cmp("D_rst_busy",  0, busy[0],  0);
        cmp("D_rst_we",    0, we[0],    0);
        cmp("D_rst_maddr", 0, maddr[0], 12'h000);
        cmp("D_rst_mdata", 0, mdata[0], 8'h00);
        clear_stats(0);
        rst[0] = 0;
        wait_done(0, 300);
        check_image0("D");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flash_loader.md
# flash_loader

Boot-time copy engine sitting directly downstream of `flash_controller`. It drives the controller's read-request handshake to fetch a contiguous image of `LENGTH` bytes, starting at SPI flash address `BASE_ADDR`. Each byte is written into an on-chip block RAM write port, for example the character ROM or colour/screen initial contents used by the VIC-II core. It then raises `done` so the video pipeline can leave its hold state.

## Interface
Parameters:
- `BASE_ADDR`, 24'h000000, first flash byte address of the image
- `LENGTH`, 4096, number of bytes to copy; legal range 1..2^`ADDR_W`
- `ADDR_W`, 12, width of the RAM write address
- `AUTO_START`, 1, 1 = start one copy automatically after reset release

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  single-cycle request to begin a copy
- `busy`  out  1  high while a copy is in progress
- `done`  out  1  sticky high after a completed copy; cleared by the next accepted start
- `flash_addr`  out  24  address to the flash controller; constant `BASE_ADDR`
- `request_read_addr`  out  1  one-cycle pulse: read from `flash_addr`
- `request_read_next`  out  1  one-cycle pulse: read the following byte
- `d_ready`  in  1  controller byte-valid level
- `d_in`  in  8  controller data byte, valid while `d_ready` is high
- `mem_we`  out  1  RAM write strobe, one cycle per byte
- `mem_addr`  out  `ADDR_W`  RAM write address, equal to the byte index
- `mem_data`  out  8  RAM write data

## Operation
- Reset is asynchronous, active-high; clock is `clk`. All outputs are registered.
- Reset values: `busy`=0, `done`=0, `request_read_addr`=0, `request_read_next`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `flash_addr`=`BASE_ADDR`, state IDLE, index 0, `auto_pending`=`AUTO_START`.
- A start is accepted in IDLE or DONE when `start`=1 or `auto_pending`=1.
  - On acceptance: `auto_pending`←0, `done`←0, `busy`←1, index←0.
  - `start` pulses received while `busy`=1 are ignored.
- States and transitions:
  - IDLE / DONE: on an accepted start, go to REQ_ADDR.
  - REQ_ADDR: assert `request_read_addr` for 1 cycle, then go to WAIT_LOW.
  - WAIT_LOW: wait for `d_ready`=0, then go to WAIT_HIGH. This wait is mandatory: the controller latches requests one cycle late, so `d_ready` can still show the previous byte for up to 2 cycles after a request.
  - WAIT_HIGH: on `d_ready`=1, capture `d_in` into `mem_data`, drive `mem_addr`←index, and go to WRITE.
  - WRITE: assert `mem_we` for 1 cycle. Then:
    - if index = `LENGTH`-1: go to DONE with `busy`←0 and `done`←1;
    - otherwise: pulse `request_read_next` in this same cycle, set index←index+1, and go to WAIT_LOW.
- Index is `ADDR_W` bits. It never wraps because it stops at `LENGTH`-1.
- `LENGTH`=1: exactly one write and zero `request_read_next` pulses.
- At most one of `request_read_addr` or `request_read_next` is high in any cycle.
- There is no timeout. If `d_ready` never rises, the block stays `busy`, which is intended for debug visibility.
- Reset mid-copy: returns immediately to the reset values; no further `mem_we`. With `AUTO_START`=1 the copy restarts from index 0 after reset release. Partially written RAM is simply overwritten.

## Timing
- Accepted start in cycle T: `busy`=1 and `request_read_addr`=1 in cycle T+1.
- `d_ready` first seen high in cycle R: `mem_data`/`mem_addr` are valid from R+1, and `mem_we`=1 in cycle R+2 together with `request_read_next` (unless it is the last byte).
- With a 1-cycle-per-bit controller, the per-byte period is controller read time (≈16 cycles) plus 3–4 loader cycles.
- On the last byte, `done` rises and `busy` falls in the cycle after the final `mem_we`.
- `mem_addr` and `mem_data` stay stable for the whole `mem_we` cycle and hold their values afterwards.

## Test plan
- Reset with `AUTO_START`=1, `LENGTH`=4, and a flash model returning 8'hA0+offset. Required response:
  - exactly one `request_read_addr` pulse with `flash_addr`=24'h000000;
  - exactly 3 `request_read_next` pulses;
  - writes (0,A0), (1,A1), (2,A2), (3,A3);
  - `done`=1 and `busy`=0 afterwards.
- `LENGTH`=1, manual start → one write (0, model byte), zero `request_read_next` pulses, `done`=1.
- Stale `d_ready` check: the model holds `d_ready`=1 for 2 cycles after `request_read_next` before dropping it → no duplicate or early write; every `mem_addr` value is written exactly once.
- `start` pulsed 5 times while `busy`=1 → no effect on the copy; the write count equals `LENGTH`.
- Reset asserted mid-copy after write index 2 → all outputs return to their reset values. The copy restarts from index 0 and completes all `LENGTH` writes.
- After `done`, pulse `start` again → `done` drops at T+1 and the full image is rewritten identically.
